// File: rtl/boid_state_mem.sv
// Ping-pong boid state store: fixed-latency tagged reads from the active bank,
// per-field writebacks into the shadow bank, and host loads into both banks.
module boid_state_mem #(
  parameter int unsigned num_boids  = 2,
  parameter int unsigned num_fields = 7,
  parameter int unsigned field_w    = 27,
  localparam int unsigned IW = (num_boids > 1) ? $clog2(num_boids) : 1,
  localparam int unsigned DW = num_fields * field_w
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IW-1:0]         which_boid,
  input  logic                  r_en_tot,
  input  logic                  r_en_itr,
  input  logic [num_fields-1:0] wb_en,
  input  logic [DW-1:0]         wb_data,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  output logic                  rd_tag,
  input  logic                  swap,
  output logic                  swap_done,
  input  logic [num_fields-1:0] ld_en,
  input  logic [IW-1:0]         ld_boid,
  input  logic [DW-1:0]         ld_data,
  output logic                  ld_ready,
  output logic                  err
);

  logic [DW-1:0] r_mem0 [num_boids];
  logic [DW-1:0] r_mem1 [num_boids];

  logic          r_bank_sel;
  logic          r_swap_pend;
  logic          r_s1_vld;
  logic          r_s1_tag;
  logic          r_s1_oob;
  logic [IW-1:0] r_s1_addr;

  logic                  w_rd_req;
  logic                  w_wb_req;
  logic                  w_boid_oob;
  logic                  w_ld_oob;
  logic                  w_idle;
  logic                  w_ld_take;
  logic                  w_ld_wr;
  logic                  w_wb_wr;
  logic                  w_swap_fire;
  logic [IW-1:0]         w_wr_addr;
  logic [DW-1:0]         w_wr_data;
  logic [num_fields-1:0] w_we0;
  logic [num_fields-1:0] w_we1;
  logic [DW-1:0]         w_rd_word;

  assign w_rd_req   = r_en_tot | r_en_itr;
  assign w_wb_req   = |wb_en;
  assign w_boid_oob = 32'(which_boid) >= num_boids;
  assign w_ld_oob   = 32'(ld_boid) >= num_boids;

  // The port is quiet when no read/writeback is issued and no response is still in flight.
  assign w_idle      = !w_rd_req && !w_wb_req && !r_s1_vld && !rd_valid;
  assign ld_ready    = w_idle;
  assign w_ld_take   = w_idle && (|ld_en);
  assign w_ld_wr     = w_ld_take && !w_ld_oob;
  assign w_wb_wr     = w_wb_req && !w_boid_oob;
  assign w_swap_fire = r_swap_pend && w_idle && !w_ld_take;

  // Loads and writebacks never coincide, so each bank sees a single write port.
  assign w_wr_addr = w_ld_wr ? ld_boid : which_boid;
  assign w_wr_data = w_ld_wr ? ld_data : wb_data;
  assign w_we0     = w_ld_wr ? ld_en : ((w_wb_wr &&  r_bank_sel) ? wb_en : '0);
  assign w_we1     = w_ld_wr ? ld_en : ((w_wb_wr && !r_bank_sel) ? wb_en : '0);

  assign w_rd_word = r_bank_sel ? r_mem1[r_s1_addr] : r_mem0[r_s1_addr];

  always_ff @(posedge clk) begin : mem_wr
    for (int f = 0; f < int'(num_fields); f++) begin
      if (w_we0[f]) r_mem0[w_wr_addr][f*field_w +: field_w] <= w_wr_data[f*field_w +: field_w];
      if (w_we1[f]) r_mem1[w_wr_addr][f*field_w +: field_w] <= w_wr_data[f*field_w +: field_w];
    end
  end

  always_ff @(posedge clk or negedge reset) begin : ctrl
    if (!reset) begin
      r_bank_sel  <= 1'b0;
      r_swap_pend <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_tag    <= 1'b0;
      r_s1_oob    <= 1'b0;
      r_s1_addr   <= '0;
      rd_valid    <= 1'b0;
      rd_tag      <= 1'b0;
      rd_data     <= '0;
      swap_done   <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Tot wins when both strobes fire, so the tag is 1 only for a lone itr.
      r_s1_vld  <= w_rd_req;
      r_s1_tag  <= !r_en_tot;
      r_s1_oob  <= w_boid_oob;
      r_s1_addr <= which_boid;
      rd_valid  <= r_s1_vld;
      if (r_s1_vld) begin
        rd_data <= r_s1_oob ? '0 : w_rd_word;
        rd_tag  <= r_s1_tag;
      end
      r_bank_sel  <= r_bank_sel ^ w_swap_fire;
      r_swap_pend <= w_swap_fire ? 1'b0 : (r_swap_pend | swap);
      swap_done   <= w_swap_fire;
      err <= err | (r_en_tot & r_en_itr) | ((w_rd_req | w_wb_req) & w_boid_oob);
    end
  end

endmodule

// File: tb/tb_boid_state_mem.sv
// Randomized bench for boid_state_mem against a cycle-level reference model of banks,
// response queue, swap handshake and sticky error.
module tb_boid_state_mem;

  localparam int unsigned NB = 3;
  localparam int unsigned NF = 7;
  localparam int unsigned FW = 27;
  localparam int unsigned IW = 2;
  localparam int unsigned DW = NF * FW;

  logic          clk;
  logic          reset;
  logic [IW-1:0] which_boid;
  logic          r_en_tot;
  logic          r_en_itr;
  logic [NF-1:0] wb_en;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_tag;
  logic          swap;
  logic          swap_done;
  logic [NF-1:0] ld_en;
  logic [IW-1:0] ld_boid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          err;

  boid_state_mem #(.num_boids(NB), .num_fields(NF), .field_w(FW)) dut (
    .clk(clk), .reset(reset), .which_boid(which_boid), .r_en_tot(r_en_tot),
    .r_en_itr(r_en_itr), .wb_en(wb_en), .wb_data(wb_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .swap(swap), .swap_done(swap_done),
    .ld_en(ld_en), .ld_boid(ld_boid), .ld_data(ld_data), .ld_ready(ld_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          tag;
  } resp_t;

  logic [FW-1:0] m_mem [2][NB][NF];
  resp_t         q [$];
  int            m_sel;
  logic          m_pend;
  logic          m_err;
  logic          exp_valid;
  logic          exp_tag;
  logic          exp_done;
  logic [DW-1:0] exp_data;
  int            cyc;
  int            last_req;
  int            n_chk;
  int            n_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] m_word(input int b, input int w);
    logic [DW-1:0] v;
    v = '0;
    for (int f = 0; f < int'(NF); f++) v[f*FW +: FW] = m_mem[b][w][f];
    return v;
  endfunction

  function automatic logic [DW-1:0] mk(input int base);
    logic [DW-1:0] v;
    for (int f = 0; f < int'(NF); f++) v[f*FW +: FW] = FW'(base + f);
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] v;
    for (int f = 0; f < int'(NF); f++) v[f*FW +: FW] = FW'($urandom);
    return v;
  endfunction

  task automatic in_idle();
    r_en_tot = 1'b0; r_en_itr = 1'b0; wb_en = '0; swap = 1'b0; ld_en = '0;
  endtask

  // One clock: model this cycle's inputs, then compare the registered outputs.
  task automatic tick();
    logic  rd_req, wb_req, idle, ld_take, fire, oob, ld_oob;
    resp_t r;
    #1;
    rd_req  = r_en_tot | r_en_itr;
    wb_req  = (wb_en != '0);
    idle    = !rd_req && !wb_req && (cyc - last_req >= 3);
    chk("ld_ready", DW'(ld_ready), DW'(idle));
    ld_take = idle && (ld_en != '0);
    fire    = m_pend && idle && !ld_take;
    oob     = int'(which_boid) >= int'(NB);
    ld_oob  = int'(ld_boid) >= int'(NB);
    if (rd_req) begin
      r.due  = cyc + 2;
      r.data = oob ? '0 : m_word(m_sel, int'(which_boid));
      r.tag  = !r_en_tot;
      q.push_back(r);
      last_req = cyc;
    end
    if ((r_en_tot && r_en_itr) || ((rd_req || wb_req) && oob)) m_err = 1'b1;
    if (wb_req && !oob)
      for (int f = 0; f < int'(NF); f++)
        if (wb_en[f]) m_mem[1-m_sel][int'(which_boid)][f] = wb_data[f*FW +: FW];
    if (ld_take && !ld_oob)
      for (int b = 0; b < 2; b++)
        for (int f = 0; f < int'(NF); f++)
          if (ld_en[f]) m_mem[b][int'(ld_boid)][f] = ld_data[f*FW +: FW];
    if (fire) m_sel = 1 - m_sel;
    m_pend   = fire ? 1'b0 : (m_pend | swap);
    exp_done = fire;
    exp_valid = 1'b0;
    if (q.size() > 0 && q[0].due == cyc + 1) begin
      r = q.pop_front();
      exp_valid = 1'b1;
      exp_data  = r.data;
      exp_tag   = r.tag;
    end
    @(negedge clk);
    cyc++;
    chk("rd_valid", DW'(rd_valid), DW'(exp_valid));
    chk("rd_tag", DW'(rd_tag), DW'(exp_tag));
    chk("rd_data", rd_data, exp_data);
    chk("swap_done", DW'(swap_done), DW'(exp_done));
    chk("err", DW'(err), DW'(m_err));
    in_idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", DW'(rd_valid), '0);
    chk("rst_tag", DW'(rd_tag), '0);
    chk("rst_data", rd_data, '0);
    chk("rst_done", DW'(swap_done), '0);
    chk("rst_err", DW'(err), '0);
    q.delete();
    m_sel = 0; m_pend = 1'b0; m_err = 1'b0;
    exp_valid = 1'b0; exp_tag = 1'b0; exp_done = 1'b0; exp_data = '0;
    last_req = cyc - 100;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic rd(input logic tot, input logic itr, input int w);
    r_en_tot = tot; r_en_itr = itr; which_boid = IW'(w);
    tick();
  endtask

  initial begin
    int cnt;
    int r;
    n_chk = 0; n_err = 0; cyc = 0; last_req = -100;
    reset = 1'b1; which_boid = '0; wb_data = '0; ld_boid = '0; ld_data = '0;
    in_idle();
    @(negedge clk);
    do_reset();

    // Host preload of every boid into both banks.
    for (int b = 0; b < int'(NB); b++) begin
      ld_en = '1; ld_boid = IW'(b); ld_data = mk(256 * (b + 1));
      tick();
    end
    rd(1'b1, 1'b0, 0);
    tick();
    chk("t1_valid", DW'(rd_valid), DW'(1));
    chk("t1_f3", DW'(rd_data[3*FW +: FW]), DW'(27'h103));

    rd(1'b0, 1'b1, 1);
    rd(1'b1, 1'b0, 0);
    chk("t2_tag_itr", DW'(rd_tag), DW'(1));
    chk("t2_f0_b1", DW'(rd_data[0 +: FW]), DW'(27'h200));
    tick();
    chk("t2_tag_tot", DW'(rd_tag), DW'(0));
    chk("t2_f0_b0", DW'(rd_data[0 +: FW]), DW'(27'h100));
    tick();

    wb_en = 7'b0011111; which_boid = IW'(1); wb_data = {NF{27'h3FF}};
    tick();
    rd(1'b1, 1'b0, 1);
    tick();
    chk("t3_shadow_hidden", DW'(rd_data[0 +: FW]), DW'(27'h200));
    swap = 1'b1;
    tick();
    repeat (4) tick();
    rd(1'b1, 1'b0, 1);
    tick();
    chk("t3_f0", DW'(rd_data[0 +: FW]), DW'(27'h3FF));
    chk("t3_f4", DW'(rd_data[4*FW +: FW]), DW'(27'h3FF));
    chk("t3_f5", DW'(rd_data[5*FW +: FW]), DW'(27'h205));
    chk("t3_f6", DW'(rd_data[6*FW +: FW]), DW'(27'h206));

    rd(1'b1, 1'b0, 0);
    swap = 1'b1;
    tick();
    swap = 1'b1;
    tick();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (swap_done) cnt++;
      tick();
    end
    chk("t4_done_count", DW'(cnt), DW'(1));

    rd(1'b1, 1'b1, 0);
    tick();
    chk("t5_both_tag", DW'(rd_tag), DW'(0));
    chk("t5_err", DW'(err), DW'(1));
    rd(1'b1, 1'b0, 3);
    tick();
    chk("t5_oob_data", rd_data, '0);
    chk("t5_err_sticky", DW'(err), DW'(1));

    rd(1'b1, 1'b0, 0);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_valid) cnt++;
    end
    chk("t6_no_valid", DW'(cnt), '0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      which_boid = ($urandom_range(0, 149) == 0) ? IW'(3) : IW'($urandom_range(0, NB - 1));
      if (r < 50) r_en_tot = 1'b1;
      else if (r < 100) r_en_itr = 1'b1;
      else if (r == 199) begin r_en_tot = 1'b1; r_en_itr = 1'b1; end
      if ($urandom_range(0, 4) == 0) begin
        wb_en = NF'($urandom_range(1, (1 << NF) - 1));
        wb_data = rnd_word();
      end
      if ($urandom_range(0, 5) == 0) begin
        ld_en = NF'($urandom_range(1, (1 << NF) - 1));
        ld_boid = ($urandom_range(0, 29) == 0) ? IW'(3) : IW'($urandom_range(0, NB - 1));
        ld_data = rnd_word();
      end
      swap = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
